// File: rtl/lfsr_enc_pkg.sv
// Shared types, constants and helpers for the LFSR stream encoder.
// Included by the encoder top and its LFSR register sub-block.
package lfsr_enc_pkg;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned LFSR_W = 6;
    localparam int unsigned PRE_W  = 6;
    localparam int unsigned PAT_W  = 3;
    localparam int unsigned N_TAPS = 6;

    localparam logic [DATA_W-1:0] PRE_CHAR = 8'h5F;

    localparam logic [LFSR_W-1:0] TAPS [N_TAPS] = '{
        6'h21, 6'h2D, 6'h30, 6'h33, 6'h36, 6'h39
    };

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        MRD  = 3'd2,
        MWR  = 3'd3,
        DONE = 3'd4
    } state_e;

    // Run lengths captured when a job is accepted
    typedef struct packed {
        logic [PRE_W-1:0]  pre_len;
        logic [ADDR_W-1:0] msg_len;
    } cfg_t;

    // Pattern indices beyond the table fall back to entry 0
    function automatic logic [LFSR_W-1:0] taps_sel(input logic [PAT_W-1:0] pat);
        logic [LFSR_W-1:0] t;
        t = TAPS[0];
        case (pat)
            3'd1:    t = TAPS[1];
            3'd2:    t = TAPS[2];
            3'd3:    t = TAPS[3];
            3'd4:    t = TAPS[4];
            3'd5:    t = TAPS[5];
            default: t = TAPS[0];
        endcase
        return t;
    endfunction

endpackage

// File: rtl/lfsr_encoder_lfsr6.sv
// 6-bit Fibonacci LFSR register: loads a seed, shifts left with the
// parity of the tapped bits entering at bit 0.
module lfsr6
    import lfsr_enc_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic              i_step,
    input  logic [LFSR_W-1:0] i_seed,
    input  logic [LFSR_W-1:0] i_taps,
    output logic [LFSR_W-1:0] o_state
);

    logic [LFSR_W-1:0] r_state;
    logic              w_fb;

    assign w_fb = ^(r_state & i_taps);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= '0;
        end else if (i_load) begin
            r_state <= i_seed;
        end else if (i_step) begin
            r_state <= {r_state[LFSR_W-2:0], w_fb};
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/lfsr_encoder.sv
// Encryption front end: writes a keyed preamble followed by the keyed
// contents of the source RAM into the destination RAM.
module lfsr_encoder
    import lfsr_enc_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [PAT_W-1:0]  i_pat_sel,
    input  logic [LFSR_W-1:0] i_seed,
    input  logic [PRE_W-1:0]  i_pre_len,
    input  logic [ADDR_W-1:0] i_msg_len,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [DATA_W-1:0] i_rd_data,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [DATA_W-1:0] o_wr_data,
    output logic              o_busy,
    output logic              o_done
);

    state_e            r_state;
    state_e            w_state_nxt;
    cfg_t              r_cfg;
    logic [LFSR_W-1:0] r_taps;
    logic [PRE_W-1:0]  r_pre_cnt;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [ADDR_W-1:0] r_wr_addr;
    logic              r_wr_en;
    logic              r_busy;
    logic              r_done;

    logic              w_accept;
    logic              w_step;
    logic              w_pre_last;
    logic              w_msg_last;
    logic [PRE_W:0]    w_pre_cnt_inc;
    logic [ADDR_W:0]   w_msg_idx_inc;
    logic              w_wr_en_nxt;
    logic              w_busy_nxt;
    logic              w_done_nxt;
    logic [LFSR_W-1:0] w_key;
    logic [DATA_W-1:0] w_plain;

    assign w_accept      = (r_state == IDLE) && i_start;
    assign w_step        = (r_state == PRE) || (r_state == MWR);
    assign w_pre_cnt_inc = {1'b0, r_pre_cnt} + (PRE_W+1)'(1);
    assign w_msg_idx_inc = {1'b0, r_rd_addr} + (ADDR_W+1)'(1);
    assign w_pre_last    = (w_pre_cnt_inc == {1'b0, r_cfg.pre_len});
    assign w_msg_last    = (w_msg_idx_inc == {1'b0, r_cfg.msg_len});

    // The LFSR always holds the key of the byte currently on the write port
    lfsr6 u_lfsr (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (w_accept),
        .i_step  (w_step),
        .i_seed  (i_seed),
        .i_taps  (r_taps),
        .o_state (w_key)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    if (i_pre_len != '0) begin
                        w_state_nxt = PRE;
                    end else if (i_msg_len != '0) begin
                        w_state_nxt = MRD;
                    end else begin
                        w_state_nxt = DONE;
                    end
                end
            end
            PRE: begin
                if (w_pre_last) begin
                    w_state_nxt = (r_cfg.msg_len != '0) ? MRD : DONE;
                end
            end
            MRD:     w_state_nxt = MWR;
            MWR:     w_state_nxt = w_msg_last ? DONE : MRD;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Control outputs are decoded from the next state so they line up with it
    always_comb begin
        w_wr_en_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        case (w_state_nxt)
            PRE: begin
                w_wr_en_nxt = 1'b1;
                w_busy_nxt  = 1'b1;
            end
            MRD: begin
                w_busy_nxt  = 1'b1;
            end
            MWR: begin
                w_wr_en_nxt = 1'b1;
                w_busy_nxt  = 1'b1;
            end
            DONE: begin
                w_done_nxt  = 1'b1;
            end
            default: begin
                w_wr_en_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_en   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_cfg     <= '0;
            r_taps    <= '0;
            r_pre_cnt <= '0;
            r_rd_addr <= '0;
            r_wr_addr <= '0;
        end else begin
            r_wr_en <= w_wr_en_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            if (w_accept) begin
                r_cfg.pre_len <= i_pre_len;
                r_cfg.msg_len <= i_msg_len;
                r_taps        <= taps_sel(i_pat_sel);
                r_pre_cnt     <= '0;
                r_rd_addr     <= '0;
                r_wr_addr     <= '0;
            end else begin
                if (r_state == PRE) begin
                    r_pre_cnt <= w_pre_cnt_inc[PRE_W-1:0];
                end
                if (r_state == MWR) begin
                    r_rd_addr <= w_msg_idx_inc[ADDR_W-1:0];
                end
                // Address wraps naturally at the RAM depth
                if (w_step) begin
                    r_wr_addr <= r_wr_addr + ADDR_W'(1);
                end
            end
        end
    end

    // Read data arrives in the write cycle itself, so the key is applied here
    assign w_plain   = (r_state == MWR) ? i_rd_data : PRE_CHAR;
    assign o_wr_data = r_wr_en ? (w_plain ^ {(DATA_W-LFSR_W)'(0), w_key}) : '0;

    assign o_rd_addr = r_rd_addr;
    assign o_wr_addr = r_wr_addr;
    assign o_wr_en   = r_wr_en;
    assign o_busy    = r_busy;
    assign o_done    = r_done;

endmodule

// File: tb/tb_lfsr_encoder.sv
// Self-checking bench for lfsr_encoder with RAM models and a per-cycle
// reference derived from the job parameters.
module tb_lfsr_encoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [2:0] pat_sel = '0;
    logic [5:0] seed = '0;
    logic [5:0] pre_len = '0;
    logic [9:0] msg_len = '0;
    logic [9:0] rd_addr;
    logic [7:0] rd_data;
    logic       wr_en;
    logic [9:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       done;

    logic [7:0] src [1024];
    logic [7:0] dst [1024];
    logic [5:0] keys [1100];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lfsr_encoder dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_start   (start),
        .i_pat_sel (pat_sel),
        .i_seed    (seed),
        .i_pre_len (pre_len),
        .i_msg_len (msg_len),
        .o_rd_addr (rd_addr),
        .i_rd_data (rd_data),
        .o_wr_en   (wr_en),
        .o_wr_addr (wr_addr),
        .o_wr_data (wr_data),
        .o_busy    (busy),
        .o_done    (done)
    );

    // Single-port RAM models: registered read, synchronous write
    always @(posedge clk) begin
        rd_data <= src[rd_addr];
        if (wr_en) dst[wr_addr] <= wr_data;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [5:0] ref_taps(input logic [2:0] p);
        case (p)
            3'd1:    return 6'h2D;
            3'd2:    return 6'h30;
            3'd3:    return 6'h33;
            3'd4:    return 6'h36;
            3'd5:    return 6'h39;
            default: return 6'h21;
        endcase
    endfunction

    // Shift left by one (mod 64), feed in the parity of the tapped bits
    function automatic logic [5:0] ref_next(input logic [5:0] s, input logic [5:0] t);
        int v;
        v = ((int'(s) * 2) % 64) + ($countones(s & t) % 2);
        return 6'(v);
    endfunction

    task automatic run_case(input logic [2:0] pat, input logic [5:0] sd, input int pre, input int msg);
        int         total;
        int         last;
        int         widx;
        int         j;
        logic       exp_we;
        logic       is_rd;
        logic [5:0] key;
        logic [7:0] plain;
        total = pre + msg;
        last  = pre + 2 * msg + 1;
        key   = sd;
        for (int k = 0; k < total; k++) begin
            keys[k] = key;
            key = ref_next(key, ref_taps(pat));
        end

        @(negedge clk);
        start   = 1'b1;
        pat_sel = pat;
        seed    = sd;
        pre_len = 6'(pre);
        msg_len = 10'(msg);
        @(posedge clk);
        for (int n = 1; n <= last + 1; n++) begin
            @(negedge clk);
            exp_we = 1'b0;
            is_rd  = 1'b0;
            widx   = 0;
            j      = 0;
            if (n <= pre) begin
                exp_we = 1'b1;
                widx   = n - 1;
            end else if (n <= pre + 2 * msg) begin
                j = (n - pre - 1) / 2;
                if (((n - pre) % 2) == 0) begin
                    exp_we = 1'b1;
                    widx   = pre + j;
                end else begin
                    is_rd = 1'b1;
                end
            end
            check_val("wr_en", 32'(wr_en), 32'(exp_we));
            if (exp_we) begin
                plain = (widx < pre) ? 8'h5F : src[widx - pre];
                check_val("wr_addr", 32'(wr_addr), 32'(widx % 1024));
                check_val("wr_data", 32'(wr_data), 32'(plain ^ {2'b00, keys[widx]}));
            end
            if (is_rd) check_val("rd_addr", 32'(rd_addr), 32'(j));
            check_val("busy", 32'(busy), 32'(n < last));
            check_val("done", 32'(done), 32'(n == last));
            // Input noise while busy must not disturb the job
            if (n < last) begin
                start   = 1'($urandom);
                pat_sel = 3'($urandom);
                seed    = 6'($urandom);
                pre_len = 6'($urandom);
                msg_len = 10'($urandom);
            end else begin
                start = 1'b0;
            end
        end

        if (total > 0 && total <= 1024) begin
            for (int k = 0; k < total; k++) begin
                plain = (k < pre) ? 8'h5F : src[k - pre];
                check_val("decrypt", 32'(dst[k] ^ {2'b00, keys[k]}), 32'(plain));
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) src[i] = 8'($urandom);
        src[0] = 8'h41;

        repeat (3) @(negedge clk);
        check_val("rst_rd_addr", 32'(rd_addr), 32'd0);
        check_val("rst_wr_addr", 32'(wr_addr), 32'd0);
        check_val("rst_wr_data", 32'(wr_data), 32'd0);
        check_val("rst_wr_en",   32'(wr_en),   32'd0);
        check_val("rst_busy",    32'(busy),    32'd0);
        check_val("rst_done",    32'(done),    32'd0);
        rst = 1'b0;

        run_case(3'd0, 6'h01, 3, 0);
        run_case(3'd0, 6'h01, 0, 1);
        run_case(3'd0, 6'h01, 2, 4);
        run_case(3'd7, 6'h2A, 5, 6);
        run_case(3'd0, 6'h2A, 5, 6);
        run_case(3'd6, 6'h13, 1, 3);
        run_case(3'd3, 6'h00, 4, 4);
        run_case(3'd5, 6'h3F, 0, 0);
        run_case(3'd2, 6'h3F, 63, 2);
        for (int r = 0; r < 6; r++) begin
            run_case(3'($urandom_range(0, 7)), 6'($urandom),
                     $urandom_range(0, 12), $urandom_range(0, 20));
        end

        // Reset during a message write aborts the job
        @(negedge clk);
        start   = 1'b1;
        pat_sel = 3'd1;
        seed    = 6'h05;
        pre_len = 6'd0;
        msg_len = 10'd5;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_val("abort_pre_wr_en", 32'(wr_en), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_val("abort_wr_en", 32'(wr_en), 32'd0);
        check_val("abort_busy",  32'(busy),  32'd0);
        check_val("abort_done",  32'(done),  32'd0);
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check_val("abort_idle_wr_en", 32'(wr_en), 32'd0);
            check_val("abort_idle_done",  32'(done),  32'd0);
        end

        run_case(3'd4, 6'h21, 10, 1020);
        run_case(3'd1, 6'h0B, 2, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
